bn_select_n_rr: RTL and testbench
=================================

BN_SELECT_N_RR -- requirements
Module: bn_select_n_rr

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 8: number of input channels, minimum 2.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8: bits per channel word.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = external one-hot select; 1 = round-robin arbitration.
REQ-007 sel  input  CHANNELS  one-hot channel select, used only in mode 0.
REQ-008 in_valid  input  CHANNELS  per-channel word-valid flags.
REQ-009 in_data  input  CHANNELS*DATA_WIDTH  packed words; channel i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_ready  output  CHANNELS  per-channel accept strobe, combinational.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.
REQ-013 out_data  output  DATA_WIDTH  registered word.
REQ-014 out_grant  output  CHANNELS  registered one-hot source channel of out_data.
REQ-015 sel_err  output  1  registered one-cycle pulse: mode-0 select was invalid.

Function
REQ-016 The output stage SHALL be a two-state FSM:
- EMPTY when out_valid=0.
- FULL when out_valid=1.
REQ-017 load_en SHALL equal (!out_valid | out_ready).
REQ-018 Grant in mode 0 SHALL equal sel when sel is one-hot and in_valid at that channel is 1; otherwise grant SHALL be zero.
REQ-019 Grant in mode 1 SHALL go to the first channel with in_valid=1, searching upward from ptr+1 and wrapping from CHANNELS-1 to 0; grant SHALL be zero if no channel is valid.
REQ-020 in_ready SHALL equal grant & {CHANNELS{load_en}} and SHALL be 0 while reset=1.
REQ-021 A transfer on channel i SHALL occur when in_valid[i] & in_ready[i]; at most one channel transfers per cycle.
REQ-022 On a transfer, the next edge SHALL set:
- out_data = channel i word.
- out_grant = one-hot i.
- out_valid = 1.
- ptr = i.
Latency is one cycle.
REQ-023 When out_valid=1, out_ready=1 and there is no transfer, out_valid SHALL clear. out_data and out_grant SHALL hold their values.
REQ-024 When out_valid=1 and out_ready=0, out_data, out_grant and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-025 A simultaneous downstream accept and upstream transfer SHALL keep out_valid=1 and load the new word, giving full throughput with no bubble.
REQ-026 ptr SHALL update on transfers in both modes and SHALL NOT update otherwise.
REQ-027 A mode change SHALL take effect in the same cycle; ptr is retained across the change.
REQ-028 sel_err SHALL pulse for exactly the cycle after any cycle with mode=0 and sel zero or multi-hot, regardless of in_valid or load_en.
REQ-029 Input data SHALL never pass combinationally to out_data.
REQ-030 out_data SHALL never be driven to Z.

Reset
REQ-031 Reset SHALL set:
- out_valid = 0
- out_data = 0
- out_grant = 0
- sel_err = 0
- ptr = CHANNELS-1, so channel 0 is searched first.
REQ-032 Reset asserted mid-transfer SHALL discard the held word; no transfer completes on a reset edge.

Structure
REQ-033 A shared package SHALL hold:
- mode encodings MODE_ONEHOT=0 and MODE_RR=1;
- a one-hot check function;
- a one-hot-to-index function.
REQ-034 The rotating-priority search SHALL be a combinational sub-module bn_rr_arbiter with ports (req, ptr, grant), parametrised by CHANNELS.
REQ-035 ptr SHALL be $clog2(CHANNELS) bits wide.

Verification
REQ-036 CHANNELS=4, DATA_WIDTH=8, mode=1, all valid, words 8'h10/11/12/13, out_ready=1 -> out_data 10,11,12,13,10 on consecutive cycles, and out_grant rotating 0001, 0010, 0100, 1000, 0001.
REQ-037 mode=1, in_valid=4'b1010, out_ready held at 0 for 3 cycles -> out_grant=0010 and data held; in_ready=0 during the stall; after release, the next word comes from channel 3.
REQ-038 mode=0, sel=4'b0100, ch2 valid with 8'hA5 -> out_data=A5 and out_grant=0100 one cycle later; with sel=4'b0110 -> no transfer and sel_err=1 for one cycle; with sel=0 -> same result.
REQ-039 mode=0 with a ch1 transfer, then switch to mode=1 with all channels valid -> first round-robin grant is channel 2.
REQ-040 reset asserted while out_valid=1 and in_valid=all ones -> next cycle out_valid=0, out_data=0 and in_ready=0; after release, the first grant is channel 0.

Source files
------------

// File: rtl/bn_select_n_rr_pkg.sv
// Shared types and helpers for the N-way selector.
// Mode encodings, output-stage states, one-hot utilities.
package bn_select_n_rr_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Widest channel vector the helpers accept
    localparam int MAX_CH = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bn_select_n_rr_if.sv
// Channel-side and output-side signal bundle of the selector.
// master drives the stimulus side, slave is the selector.
interface bn_select_n_rr_if #(
    parameter int CHANNELS   = 8,
    parameter int DATA_WIDTH = 8
) ();

    logic                           mode;
    logic [CHANNELS-1:0]            sel;
    logic [CHANNELS-1:0]            in_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]            in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [CHANNELS-1:0]            out_grant;
    logic                           sel_err;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_grant, sel_err
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_grant, sel_err
    );

endinterface

// File: rtl/bn_rr_arbiter.sv
// Rotating-priority search: first requester above ptr, wrapping.
// Purely combinational; grant is zero when nothing requests.
module bn_rr_arbiter #(
    parameter int CHANNELS = 8,
    localparam int PTR_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk ptr+1 .. ptr+CHANNELS modulo CHANNELS, take first request
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = PTR_W'((int'(ptr) + i) % CHANNELS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bn_select_n_rr.sv
// N-channel selector into a single registered output slot.
// External one-hot select or round-robin, full-throughput stage.
module bn_select_n_rr
    import bn_select_n_rr_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    bn_select_n_rr_if.slave   bus
);

    localparam int PTR_W = $clog2(CHANNELS);

    out_state_t              state_q, state_n;
    logic [PTR_W-1:0]        ptr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CHANNELS-1:0]     ogrant_q;
    logic                    err_q;

    logic                    load_en;
    logic                    sel_ok;
    logic [CHANNELS-1:0]     grant_sel;
    logic [CHANNELS-1:0]     grant_rr;
    logic [CHANNELS-1:0]     grant;
    logic [CHANNELS-1:0]     ready;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   word;

    bn_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .grant (grant_rr)
    );

    assign load_en = (state_q == ST_EMPTY) | bus.out_ready;
    assign sel_ok  = is_onehot(MAX_CH'(bus.sel));

    // Select grant source, derive ready strobes and the chosen word
    always_comb begin
        grant_sel = '0;
        if (sel_ok && ((bus.sel & bus.in_valid) != '0)) begin
            grant_sel = bus.sel;
        end
        grant = (bus.mode == MODE_RR) ? grant_rr : grant_sel;
        ready = reset ? '0 : (grant & {CHANNELS{load_en}});
        xfer  = |(bus.in_valid & ready);
        word  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) word = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output slot next state: load wins, otherwise drain on accept
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_EMPTY: if (xfer) state_n = ST_FULL;
            ST_FULL:  if (!xfer && bus.out_ready) state_n = ST_EMPTY;
            default:  state_n = ST_EMPTY;
        endcase
    end

    // State, output word, grant, pointer and select-error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            ogrant_q <= '0;
            ptr_q    <= PTR_W'(CHANNELS - 1);
            err_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            err_q   <= (bus.mode == MODE_ONEHOT) && !sel_ok;
            if (xfer) begin
                data_q   <= word;
                ogrant_q <= grant;
                ptr_q    <= PTR_W'(onehot_to_idx(MAX_CH'(grant)));
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_grant = ogrant_q;
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_bn_select_n_rr.sv
// Directed bench for bn_select_n_rr, CHANNELS=4, DATA_WIDTH=8.
// Expected values are hand-computed constants.
module tb_bn_select_n_rr;

    localparam int CH = 4;
    localparam int DW = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bn_select_n_rr_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

    bn_select_n_rr #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic v,
                           input logic [7:0] d, input logic [3:0] g);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".grant"}, 32'(bus.out_grant), 32'(g));
    endtask

    initial begin
        logic [7:0] rr_d [5];
        logic [3:0] rr_g [5];
        rr_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        checks   = 0;
        failures = 0;

        reset         = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b0;
        tick();
        tick();
        out_chk("rst", 1'b0, 8'h00, 4'b0000);
        chk("rst.sel_err", 32'(bus.sel_err), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);

        // round robin, all valid, continuous accept
        reset         = 1'b0;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        chk("rr.first_ready", 32'(bus.in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            out_chk($sformatf("rr%0d", i), 1'b1, rr_d[i], rr_g[i]);
        end
        chk("rr.sel_err", 32'(bus.sel_err), 32'd0);

        // stall with in_valid=1010
        bus.in_valid = 4'b1010;
        tick();
        out_chk("stl.load", 1'b1, 8'h11, 4'b0010);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stl%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
            out_chk($sformatf("stl%0d", i), 1'b1, 8'h11, 4'b0010);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stl.rel_ready", 32'(bus.in_ready), 32'b1000);
        tick();
        out_chk("stl.rel", 1'b1, 8'h13, 4'b1000);

        // drain with nothing valid: valid clears, data holds
        bus.in_valid = '0;
        tick();
        out_chk("drain", 1'b0, 8'h13, 4'b1000);

        // mode 0 external select
        bus.mode     = 1'b0;
        bus.in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.sel      = 4'b0100;
        bus.in_valid = 4'b0100;
        tick();
        out_chk("sel", 1'b1, 8'hA5, 4'b0100);
        chk("sel.err", 32'(bus.sel_err), 32'd0);
        bus.sel      = 4'b0110;
        bus.in_valid = 4'b0110;
        #1;
        chk("multi.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        out_chk("multi", 1'b0, 8'hA5, 4'b0100);
        chk("multi.err", 32'(bus.sel_err), 32'd1);
        bus.sel = 4'b0000;
        #1;
        chk("zero.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        out_chk("zero", 1'b0, 8'hA5, 4'b0100);
        chk("zero.err", 32'(bus.sel_err), 32'd1);
        bus.sel      = 4'b0100;
        bus.in_valid = 4'b0000;
        tick();
        chk("err.clear", 32'(bus.sel_err), 32'd0);
        chk("err.noxfer", 32'(bus.out_valid), 32'd0);

        // ch1 in mode 0, then switch to round robin
        bus.sel      = 4'b0010;
        bus.in_valid = 4'b0010;
        tick();
        out_chk("m0ch1", 1'b1, 8'h11, 4'b0010);
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        #1;
        chk("sw.in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        out_chk("sw", 1'b1, 8'hA5, 4'b0100);

        // reset while full and all valid
        reset = 1'b1;
        #1;
        chk("rst2.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        out_chk("rst2", 1'b0, 8'h00, 4'b0000);
        chk("rst2.in_ready_hold", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst2.rel_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        out_chk("rst2.first", 1'b1, 8'h10, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
